// File: rtl/rs_alu_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_dispatch_pkg
// Description : Shared constants for the ALU reservation station:
//               default sizes, tag/opcode widths and the op_map opcode values.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_alu_dispatch_pkg;

    localparam int c_rs_size = 16;
    localparam int c_rob_w   = 4;
    localparam int c_op_w    = 6;
    localparam int c_data_w  = 32;

    // op_map encoding for integer ALU operations (0 is the idle/no-op code)
    localparam logic [c_op_w-1:0] c_op_add = 6'd1;
    localparam logic [c_op_w-1:0] c_op_sub = 6'd2;
    localparam logic [c_op_w-1:0] c_op_and = 6'd3;
    localparam logic [c_op_w-1:0] c_op_or  = 6'd4;
    localparam logic [c_op_w-1:0] c_op_xor = 6'd5;

endpackage
`default_nettype wire

// File: rtl/rs_alu_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_dispatch_if
// Description : Bundle between issue stage / CDB snoop and the ALU
//               reservation station, plus the dispatch bus to the ALU.
//               master : issue stage side (drives issue, CDB, rdy, clear)
//               slave  : reservation station side
// Ports       : rdy, clear, in_* (issue), cdb_alu_*, cdb_lsb_* (broadcasts),
//               rs_full, alu_* (dispatch)
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_alu_dispatch_if
    import rs_alu_dispatch_pkg::*;
#(
    parameter int ROB_W = c_rob_w,
    parameter int OP_W  = c_op_w
);
    logic             rdy;
    logic             clear;
    logic             in_valid;
    logic [OP_W-1:0]  in_opcode_id;
    logic [31:0]      in_vj;
    logic [31:0]      in_vk;
    logic [ROB_W-1:0] in_qj;
    logic [ROB_W-1:0] in_qk;
    logic             in_qj_busy;
    logic             in_qk_busy;
    logic [31:0]      in_A;
    logic [ROB_W-1:0] in_rob_pos;
    logic             cdb_alu_valid;
    logic [ROB_W-1:0] cdb_alu_rob_pos;
    logic [31:0]      cdb_alu_val;
    logic             cdb_lsb_valid;
    logic [ROB_W-1:0] cdb_lsb_rob_pos;
    logic [31:0]      cdb_lsb_val;
    logic             rs_full;
    logic             alu_valid;
    logic [OP_W-1:0]  alu_opcode_id;
    logic [31:0]      alu_vj;
    logic [31:0]      alu_vk;
    logic [31:0]      alu_A;
    logic [ROB_W-1:0] alu_rob_pos;

    modport master (
        output rdy, clear, in_valid, in_opcode_id, in_vj, in_vk, in_qj, in_qk,
               in_qj_busy, in_qk_busy, in_A, in_rob_pos,
               cdb_alu_valid, cdb_alu_rob_pos, cdb_alu_val,
               cdb_lsb_valid, cdb_lsb_rob_pos, cdb_lsb_val,
        input  rs_full, alu_valid, alu_opcode_id, alu_vj, alu_vk, alu_A, alu_rob_pos
    );

    modport slave (
        input  rdy, clear, in_valid, in_opcode_id, in_vj, in_vk, in_qj, in_qk,
               in_qj_busy, in_qk_busy, in_A, in_rob_pos,
               cdb_alu_valid, cdb_alu_rob_pos, cdb_alu_val,
               cdb_lsb_valid, cdb_lsb_rob_pos, cdb_lsb_val,
        output rs_full, alu_valid, alu_opcode_id, alu_vj, alu_vk, alu_A, alu_rob_pos
    );
endinterface
`default_nettype wire

// File: rtl/rs_alu_dispatch_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_dispatch_prio_enc
// Description : Lowest-set-bit priority encoder.
// Ports       : i_vec   - request vector
//               o_idx   - index of lowest set bit (0 when none)
//               o_found - at least one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu_dispatch_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  wire logic [WIDTH-1:0] i_vec,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_found
);
    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rs_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_dispatch
// Description : Reservation station for the integer ALU. Buffers issued
//               instructions, wakes pending operands from the ALU and LSB
//               CDBs, and dispatches the lowest-index ready entry each cycle.
// Ports       : clk, rst (sync, active-high)
//               bus (rs_alu_dispatch_if.slave): rdy stall, clear flush,
//               in_* issue, cdb_* broadcasts, rs_full, alu_* dispatch regs
// Config      : RS_BYPASS_EN - when defined, a fully ready incoming instr
//               with no stored entry ready goes straight to the alu_* regs.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu_dispatch
    import rs_alu_dispatch_pkg::*;
#(
    parameter int RS_SIZE = c_rs_size,
    parameter int ROB_W   = c_rob_w,
    parameter int OP_W    = c_op_w
) (
    input wire logic         clk,
    input wire logic         rst,
    rs_alu_dispatch_if.slave bus
);
    localparam int c_idx_w = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_valid;
    logic [RS_SIZE-1:0] r_qj_busy;
    logic [RS_SIZE-1:0] r_qk_busy;
    logic [OP_W-1:0]    r_op  [RS_SIZE];
    logic [31:0]        r_vj  [RS_SIZE];
    logic [31:0]        r_vk  [RS_SIZE];
    logic [31:0]        r_a   [RS_SIZE];
    logic [ROB_W-1:0]   r_qj  [RS_SIZE];
    logic [ROB_W-1:0]   r_qk  [RS_SIZE];
    logic [ROB_W-1:0]   r_rob [RS_SIZE];

    logic               r_alu_valid;
    logic [OP_W-1:0]    r_alu_op;
    logic [31:0]        r_alu_vj;
    logic [31:0]        r_alu_vk;
    logic [31:0]        r_alu_a;
    logic [ROB_W-1:0]   r_alu_rob;

    logic [RS_SIZE-1:0] w_free_vec;
    logic [RS_SIZE-1:0] w_ready_vec;
    logic [c_idx_w-1:0] w_free_idx;
    logic [c_idx_w-1:0] w_ready_idx;
    logic               w_free_found;
    logic               w_ready_found;
    logic               w_issue;
    logic               w_bypass;
    logic               w_in_qj_busy;
    logic               w_in_qk_busy;
    logic [31:0]        w_in_vj;
    logic [31:0]        w_in_vk;

    assign w_free_vec  = ~r_valid;
    assign w_ready_vec = r_valid & ~r_qj_busy & ~r_qk_busy;

    rs_alu_dispatch_prio_enc #(.WIDTH(RS_SIZE)) u_free_enc (
        .i_vec   (w_free_vec),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_alu_dispatch_prio_enc #(.WIDTH(RS_SIZE)) u_ready_enc (
        .i_vec   (w_ready_vec),
        .o_idx   (w_ready_idx),
        .o_found (w_ready_found)
    );

    // Same-cycle forwarding: an incoming busy operand whose tag is on a CDB
    // right now is captured immediately instead of waiting for a wake-up.
    always_comb begin
        w_in_qj_busy = bus.in_qj_busy;
        w_in_vj      = bus.in_vj;
        if (bus.in_qj_busy) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_rob_pos == bus.in_qj) begin
                w_in_qj_busy = 1'b0;
                w_in_vj      = bus.cdb_alu_val;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_pos == bus.in_qj) begin
                w_in_qj_busy = 1'b0;
                w_in_vj      = bus.cdb_lsb_val;
            end
        end
        w_in_qk_busy = bus.in_qk_busy;
        w_in_vk      = bus.in_vk;
        if (bus.in_qk_busy) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_rob_pos == bus.in_qk) begin
                w_in_qk_busy = 1'b0;
                w_in_vk      = bus.cdb_alu_val;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_pos == bus.in_qk) begin
                w_in_qk_busy = 1'b0;
                w_in_vk      = bus.cdb_lsb_val;
            end
        end
    end

    // Full is judged on pre-edge occupancy; an issue while full is dropped.
    assign w_issue = bus.in_valid && w_free_found;

`ifdef RS_BYPASS_EN
    assign w_bypass = w_issue && !w_in_qj_busy && !w_in_qk_busy && !w_ready_found;
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || (bus.rdy && bus.clear)) begin
            r_valid     <= '0;
            r_qj_busy   <= '0;
            r_qk_busy   <= '0;
            r_alu_valid <= 1'b0;
            r_alu_op    <= '0;
            r_alu_vj    <= '0;
            r_alu_vk    <= '0;
            r_alu_a     <= '0;
            r_alu_rob   <= '0;
        end else if (bus.rdy) begin
            // Wake-up: both CDBs may complete different operands of one entry.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_valid[i] && r_qj_busy[i]) begin
                    if (bus.cdb_alu_valid && bus.cdb_alu_rob_pos == r_qj[i]) begin
                        r_vj[i]      <= bus.cdb_alu_val;
                        r_qj_busy[i] <= 1'b0;
                    end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_pos == r_qj[i]) begin
                        r_vj[i]      <= bus.cdb_lsb_val;
                        r_qj_busy[i] <= 1'b0;
                    end
                end
                if (r_valid[i] && r_qk_busy[i]) begin
                    if (bus.cdb_alu_valid && bus.cdb_alu_rob_pos == r_qk[i]) begin
                        r_vk[i]      <= bus.cdb_alu_val;
                        r_qk_busy[i] <= 1'b0;
                    end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_pos == r_qk[i]) begin
                        r_vk[i]      <= bus.cdb_lsb_val;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end

            // Dispatch uses pre-edge readiness, so a woken entry waits one cycle.
            if (w_ready_found) begin
                r_alu_valid          <= 1'b1;
                r_alu_op             <= r_op[w_ready_idx];
                r_alu_vj             <= r_vj[w_ready_idx];
                r_alu_vk             <= r_vk[w_ready_idx];
                r_alu_a              <= r_a[w_ready_idx];
                r_alu_rob            <= r_rob[w_ready_idx];
                r_valid[w_ready_idx] <= 1'b0;
            end else if (w_bypass) begin
                r_alu_valid <= 1'b1;
                r_alu_op    <= bus.in_opcode_id;
                r_alu_vj    <= w_in_vj;
                r_alu_vk    <= w_in_vk;
                r_alu_a     <= bus.in_A;
                r_alu_rob   <= bus.in_rob_pos;
            end else begin
                r_alu_valid <= 1'b0;
                r_alu_op    <= '0;
                r_alu_vj    <= '0;
                r_alu_vk    <= '0;
                r_alu_a     <= '0;
                r_alu_rob   <= '0;
            end

            // The free slot is never the dispatched or a woken slot (both are valid).
            if (w_issue && !w_bypass) begin
                r_valid[w_free_idx]   <= 1'b1;
                r_op[w_free_idx]      <= bus.in_opcode_id;
                r_vj[w_free_idx]      <= w_in_vj;
                r_vk[w_free_idx]      <= w_in_vk;
                r_qj[w_free_idx]      <= bus.in_qj;
                r_qk[w_free_idx]      <= bus.in_qk;
                r_qj_busy[w_free_idx] <= w_in_qj_busy;
                r_qk_busy[w_free_idx] <= w_in_qk_busy;
                r_a[w_free_idx]       <= bus.in_A;
                r_rob[w_free_idx]     <= bus.in_rob_pos;
            end
        end
    end

    assign bus.rs_full       = ~w_free_found;
    assign bus.alu_valid     = r_alu_valid;
    assign bus.alu_opcode_id = r_alu_op;
    assign bus.alu_vj        = r_alu_vj;
    assign bus.alu_vk        = r_alu_vk;
    assign bus.alu_A         = r_alu_a;
    assign bus.alu_rob_pos   = r_alu_rob;

endmodule
`default_nettype wire

// File: tb/tb_rs_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_alu_dispatch
// Description : Self-checking bench for rs_alu_dispatch. Expected dispatches
//               are pushed to a scoreboard queue when stimulus is driven and
//               popped when the ALU bus shows a valid instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_alu_dispatch;
    import rs_alu_dispatch_pkg::*;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic [3:0]  rob;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    rs_alu_dispatch_if bus ();

    rs_alu_dispatch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t actual();
        return {bus.alu_opcode_id, bus.alu_vj, bus.alu_vk, bus.alu_A, bus.alu_rob_pos};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.in_qj_busy    = 1'b0;
        bus.in_qk_busy    = 1'b0;
        bus.cdb_alu_valid = 1'b0;
        bus.cdb_lsb_valid = 1'b0;
        bus.clear         = 1'b0;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [3:0] qj, input logic [3:0] qk, input logic qjb,
                               input logic qkb, input logic [31:0] a, input logic [3:0] rob);
        bus.in_valid     = 1'b1;
        bus.in_opcode_id = op;
        bus.in_vj        = vj;
        bus.in_vk        = vk;
        bus.in_qj        = qj;
        bus.in_qk        = qk;
        bus.in_qj_busy   = qjb;
        bus.in_qk_busy   = qkb;
        bus.in_A         = a;
        bus.in_rob_pos   = rob;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rdy = 1'b0;
        drive_issue(c_op_add, 32'h1, 32'h2, 4'd0, 4'd0, 1'b0, 1'b0, 32'h3, 4'd1);
        tick();
        tick();
        idle();
        tick();
        checks++;
        if (bus.alu_valid !== 1'b0 || actual() !== exp_t'(0)) begin
            failures++;
            $display("FAIL reset_alu: valid=%b bus=%h required valid=0 bus=0", bus.alu_valid, actual());
        end
        checks++;
        if (bus.rs_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_full: got %b required 0", bus.rs_full);
        end
        rst = 1'b0;
        bus.rdy = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        exp_t e;
        drive_issue(c_op_add, 32'd5, 32'd7, 4'd0, 4'd0, 1'b0, 1'b0, 32'd0, 4'd3);
        sb.push_back({c_op_add, 32'd5, 32'd7, 32'd0, 4'd3});
        tick();
        idle();
        checks++;
        if (bus.alu_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early: alu_valid got %b required 0", bus.alu_valid);
        end
        tick();
        checks++;
        if (bus.alu_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL basic_dispatch: alu_valid got %b required 1", bus.alu_valid);
        end else begin
            e = sb.pop_front();
            if (actual() !== e) begin
                failures++;
                $display("FAIL basic_fields: got %h required %h", actual(), e);
            end
        end
        tick();
        checks++;
        if (bus.alu_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_after: alu_valid got %b required 0", bus.alu_valid);
        end
    endtask

    task automatic test_wakeup();
        exp_t e;
        logic seen;
        drive_issue(c_op_sub, 32'hDEAD, 32'd1, 4'd2, 4'd0, 1'b1, 1'b0, 32'd4, 4'd5);
        tick();
        idle();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.alu_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL wake_premature: alu_valid got 1 required 0");
        end
        bus.cdb_alu_valid   = 1'b1;
        bus.cdb_alu_rob_pos = 4'd2;
        bus.cdb_alu_val     = 32'h10;
        sb.push_back({c_op_sub, 32'h10, 32'd1, 32'd4, 4'd5});
        tick();
        idle();
        checks++;
        if (bus.alu_valid !== 1'b0) begin
            failures++;
            $display("FAIL wake_latency: alu_valid got %b required 0", bus.alu_valid);
        end
        tick();
        checks++;
        if (bus.alu_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL wake_dispatch: alu_valid got %b required 1", bus.alu_valid);
        end else begin
            e = sb.pop_front();
            if (actual() !== e) begin
                failures++;
                $display("FAIL wake_fields: got %h required %h", actual(), e);
            end
        end
    endtask

    task automatic test_forward();
        exp_t e;
        drive_issue(c_op_xor, 32'hBAD0, 32'd2, 4'd4, 4'd0, 1'b1, 1'b0, 32'd8, 4'd6);
        bus.cdb_lsb_valid   = 1'b1;
        bus.cdb_lsb_rob_pos = 4'd4;
        bus.cdb_lsb_val     = 32'd9;
        sb.push_back({c_op_xor, 32'd9, 32'd2, 32'd8, 4'd6});
        tick();
        idle();
        tick();
        checks++;
        if (bus.alu_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL fwd_dispatch: alu_valid got %b required 1", bus.alu_valid);
        end else begin
            e = sb.pop_front();
            if (actual() !== e) begin
                failures++;
                $display("FAIL fwd_fields: got %h required %h", actual(), e);
            end
        end
        tick();
    endtask

    task automatic test_full();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            drive_issue(c_op_add, 32'h0, 32'(i), 4'(i), 4'd0, 1'b1, 1'b0, 32'(i + 100), 4'(i));
            tick();
        end
        idle();
        checks++;
        if (bus.rs_full !== 1'b1 || bus.alu_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_set: rs_full=%b alu_valid=%b required 1/0", bus.rs_full, bus.alu_valid);
        end
        // Ready instruction offered while full must be dropped.
        drive_issue(c_op_or, 32'd1, 32'd1, 4'd0, 4'd0, 1'b0, 1'b0, 32'd1, 4'd15);
        tick();
        idle();
        bus.cdb_alu_valid   = 1'b1;
        bus.cdb_alu_rob_pos = 4'd7;
        bus.cdb_alu_val     = 32'h77;
        sb.push_back({c_op_add, 32'h77, 32'd7, 32'd107, 4'd7});
        tick();
        idle();
        checks++;
        if (bus.rs_full !== 1'b1 || bus.alu_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_woken: rs_full=%b alu_valid=%b required 1/0", bus.rs_full, bus.alu_valid);
        end
        tick();
        checks++;
        if (bus.alu_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL full_dispatch: alu_valid got %b required 1", bus.alu_valid);
        end else begin
            e = sb.pop_front();
            if (actual() !== e) begin
                failures++;
                $display("FAIL full_fields: got %h required %h", actual(), e);
            end
        end
        checks++;
        if (bus.rs_full !== 1'b0) begin
            failures++;
            $display("FAIL full_freed: rs_full got %b required 0", bus.rs_full);
        end
        tick();
        checks++;
        if (bus.alu_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_dropped: alu_valid got %b required 0", bus.alu_valid);
        end
        bus.clear = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_priority();
        exp_t e;
        exp_t held;
        logic [3:0] tags [6];
        logic [5:0] ops  [6];
        tags = '{4'd10, 4'd9, 4'd11, 4'd12, 4'd13, 4'd9};
        ops  = '{c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor, c_op_and};
        for (int i = 0; i < 6; i++) begin
            drive_issue(ops[i], 32'h0, 32'(i + 'h100), tags[i], 4'd0, 1'b1, 1'b0, 32'(i + 'h200), 4'(i));
            tick();
        end
        idle();
        bus.cdb_alu_valid   = 1'b1;
        bus.cdb_alu_rob_pos = 4'd9;
        bus.cdb_alu_val     = 32'h55;
        sb.push_back({c_op_sub, 32'h55, 32'h101, 32'h201, 4'd1});
        sb.push_back({c_op_and, 32'h55, 32'h105, 32'h205, 4'd5});
        tick();
        idle();
        tick();
        checks++;
        held = '0;
        if (bus.alu_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL prio_first: alu_valid got %b required 1", bus.alu_valid);
        end else begin
            e = sb.pop_front();
            held = e;
            if (actual() !== e) begin
                failures++;
                $display("FAIL prio_first_fields: got %h required %h", actual(), e);
            end
        end
        bus.rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.alu_valid !== 1'b1 || actual() !== held) begin
                failures++;
                $display("FAIL prio_hold: valid=%b bus=%h required 1 %h", bus.alu_valid, actual(), held);
            end
        end
        bus.rdy = 1'b1;
        tick();
        checks++;
        if (bus.alu_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL prio_second: alu_valid got %b required 1", bus.alu_valid);
        end else begin
            e = sb.pop_front();
            if (actual() !== e) begin
                failures++;
                $display("FAIL prio_second_fields: got %h required %h", actual(), e);
            end
        end
        tick();
        checks++;
        if (bus.alu_valid !== 1'b0) begin
            failures++;
            $display("FAIL prio_after: alu_valid got %b required 0", bus.alu_valid);
        end
    endtask

    task automatic test_clear();
        logic seen;
        // Entries with tags 10..13 remain pending; add a ready one then flush.
        drive_issue(c_op_add, 32'd1, 32'd2, 4'd0, 4'd0, 1'b0, 1'b0, 32'd3, 4'd8);
        tick();
        idle();
        bus.clear = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.alu_valid !== 1'b0 || bus.rs_full !== 1'b0) begin
            failures++;
            $display("FAIL clear_state: alu_valid=%b rs_full=%b required 0/0", bus.alu_valid, bus.rs_full);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.cdb_alu_valid   = (i < 4);
            bus.cdb_alu_rob_pos = 4'(10 + i);
            bus.cdb_alu_val     = 32'(i);
            tick();
            if (bus.alu_valid !== 1'b0) seen = 1'b1;
        end
        idle();
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL clear_flushed: alu_valid got 1 required 0");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.rdy  = 1'b0;
        bus.in_opcode_id    = '0;
        bus.in_vj           = '0;
        bus.in_vk           = '0;
        bus.in_qj           = '0;
        bus.in_qk           = '0;
        bus.in_A            = '0;
        bus.in_rob_pos      = '0;
        bus.cdb_alu_rob_pos = '0;
        bus.cdb_alu_val     = '0;
        bus.cdb_lsb_rob_pos = '0;
        bus.cdb_lsb_val     = '0;
        idle();
        test_reset();
        test_basic();
        test_wakeup();
        test_forward();
        test_full();
        test_priority();
        test_clear();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
